// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter : iterative radix-4 multiplier for the execute stage.
//
// Shares the issue/writeback handshake of the iterative divider. Handles
// mul.w (low 32 bits), mulh.w (signed high) and mulh.wu (unsigned high).
// Operands are converted to magnitudes, multiplied two bits per cycle into a
// 64-bit accumulator, and the sign is re-applied in the DONE cycle.
//
// Ports:
//   clk               clock
//   rstn              asynchronous active-low reset
//   mul_en_in         request valid, sampled only in IDLE
//   mul_op            0 = low product half, 1 = high product half
//   mul_sign          1 = operands are signed two's complement
//   mul_sr0           multiplicand
//   mul_sr1           multiplier
//   mul_addr_in       destination register
//   mul_flush         synchronous abort of the in-flight operation
//   mul_en_out        one-cycle result-valid pulse
//   stall_because_mul high while an accepted operation is unfinished
//   mul_result        selected product half (held until next completion)
//   mul_addr_out      destination of mul_result
//
// Optional feature macro: MUL_EARLY_EXIT_EN
//   When defined, BUSY jumps to DONE as soon as the remaining multiplier
//   bits are all zero. Results are identical; only latency changes.
// -----------------------------------------------------------------------------
module mul_iter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mul_en_in,
    input  logic              mul_op,
    input  logic              mul_sign,
    input  logic [31:0]       mul_sr0,
    input  logic [31:0]       mul_sr1,
    input  logic [ADDR_W-1:0] mul_addr_in,
    input  logic              mul_flush,
    output logic              mul_en_out,
    output logic              stall_because_mul,
    output logic [31:0]       mul_result,
    output logic [ADDR_W-1:0] mul_addr_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [63:0]       acc;
    logic [63:0]       mcand;
    logic [31:0]       mplier;
    logic [4:0]        cnt;
    logic              neg;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0]       sr0_mag;
    logic [31:0]       sr1_mag;
    logic [63:0]       addend;
    logic [63:0]       product;
    logic              early_exit;

    // Magnitudes: 0x80000000 negates to itself, which read as unsigned is 2^31.
    assign sr0_mag = (mul_sign && mul_sr0[31]) ? (~mul_sr0 + 32'd1) : mul_sr0;
    assign sr1_mag = (mul_sign && mul_sr1[31]) ? (~mul_sr1 + 32'd1) : mul_sr1;

    // Radix-4 partial product for the current two multiplier bits.
    always_comb begin
        addend = 64'd0;
        case (mplier[1:0])
            2'd0:    addend = 64'd0;
            2'd1:    addend = mcand;
            2'd2:    addend = mcand << 1;
            default: addend = mcand + (mcand << 1);
        endcase
    end

    assign product = neg ? (~acc + 64'd1) : acc;

`ifdef MUL_EARLY_EXIT_EN
    assign early_exit = (mplier == 32'd0);
`else
    assign early_exit = 1'b0;
`endif

    // Flush takes priority over every state and drops any same-cycle request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            acc               <= 64'd0;
            mcand             <= 64'd0;
            mplier            <= 32'd0;
            cnt               <= 5'd0;
            neg               <= 1'b0;
            op_q              <= 1'b0;
            addr_q            <= '0;
            mul_en_out        <= 1'b0;
            stall_because_mul <= 1'b0;
            mul_result        <= 32'd0;
            mul_addr_out      <= '0;
        end else if (mul_flush) begin
            state             <= IDLE;
            mul_en_out        <= 1'b0;
            stall_because_mul <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mul_en_out <= 1'b0;
                    if (mul_en_in) begin
                        acc               <= 64'd0;
                        mcand             <= {32'd0, sr0_mag};
                        mplier            <= sr1_mag;
                        cnt               <= 5'd16;
                        neg               <= mul_sign & (mul_sr0[31] ^ mul_sr1[31]);
                        op_q              <= mul_op;
                        addr_q            <= mul_addr_in;
                        stall_because_mul <= 1'b1;
                        state             <= BUSY;
                    end
                end
                BUSY: begin
                    mul_en_out <= 1'b0;
                    if (early_exit) begin
                        state <= DONE;
                    end else begin
                        acc    <= acc + addend;
                        mcand  <= mcand << 2;
                        mplier <= mplier >> 2;
                        cnt    <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    mul_result        <= op_q ? product[63:32] : product[31:0];
                    mul_addr_out      <= addr_q;
                    mul_en_out        <= 1'b1;
                    stall_because_mul <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    mul_en_out        <= 1'b0;
                    stall_because_mul <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_mul_iter : directed self-checking bench for mul_iter.
// Each scenario task drives its own stimulus and compares against
// hand-computed products, latencies and pulse counts.
// -----------------------------------------------------------------------------
module tb_mul_iter;

    logic        clk;
    logic        rstn;
    logic        mul_en_in;
    logic        mul_op;
    logic        mul_sign;
    logic [31:0] mul_sr0;
    logic [31:0] mul_sr1;
    logic [4:0]  mul_addr_in;
    logic        mul_flush;
    logic        mul_en_out;
    logic        stall_because_mul;
    logic [31:0] mul_result;
    logic [4:0]  mul_addr_out;

    int checks;
    int errors;

    mul_iter #(.ADDR_W(5)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .mul_en_in         (mul_en_in),
        .mul_op            (mul_op),
        .mul_sign          (mul_sign),
        .mul_sr0           (mul_sr0),
        .mul_sr1           (mul_sr1),
        .mul_addr_in       (mul_addr_in),
        .mul_flush         (mul_flush),
        .mul_en_out        (mul_en_out),
        .stall_because_mul (stall_because_mul),
        .mul_result        (mul_result),
        .mul_addr_out      (mul_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request (accept edge = E0) and observe 24 cycles afterwards.
    // lat is the edge index after which the first pulse was seen (-1 if none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic sign, input logic [4:0] addr,
                          output int lat, output int pulses, output int stall_cycles,
                          output logic [31:0] res, output logic [4:0] ao);
        lat = -1;
        pulses = 0;
        stall_cycles = 0;
        res = 32'd0;
        ao = 5'd0;
        @(negedge clk);
        mul_en_in = 1'b1;
        mul_sr0 = a;
        mul_sr1 = b;
        mul_op = op;
        mul_sign = sign;
        mul_addr_in = addr;
        @(posedge clk);
        #1;
        mul_en_in = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (stall_because_mul) stall_cycles++;
            if (mul_en_out) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = mul_result;
                    ao = mul_addr_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        mul_en_in = 1'b0;
        mul_op = 1'b0;
        mul_sign = 1'b0;
        mul_sr0 = 32'd0;
        mul_sr1 = 32'd0;
        mul_addr_in = 5'd0;
        mul_flush = 1'b0;
        #12;
        checks++;
        if (mul_en_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_en_out: got %b expected 0", mul_en_out); end
        checks++;
        if (stall_because_mul !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_because_mul); end
        checks++;
        if (mul_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", mul_result); end
        checks++;
        if (mul_addr_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", mul_addr_out); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, pulses, st;
        logic [31:0] res;
        logic [4:0] ao;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 5'd3, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'h0000_0000) begin errors++; $display("[TB] FAIL u_low_2e32 result: got %h expected 00000000", res); end
        checks++;
        if (ao !== 5'd3) begin errors++; $display("[TB] FAIL u_low_2e32 addr: got %0d expected 3", ao); end
        checks++;
        if (lat !== 17) begin errors++; $display("[TB] FAIL u_low_2e32 latency: got %0d expected 17", lat); end
        checks++;
        if (pulses !== 1) begin errors++; $display("[TB] FAIL u_low_2e32 pulses: got %0d expected 1", pulses); end
        checks++;
        if (st !== 17) begin errors++; $display("[TB] FAIL u_low_2e32 stall cycles: got %0d expected 17", st); end

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd10, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL u_high_max result: got %h expected fffffffe", res); end
        checks++;
        if (ao !== 5'd10) begin errors++; $display("[TB] FAIL u_high_max addr: got %0d expected 10", ao); end

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd11, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'h0000_0001) begin errors++; $display("[TB] FAIL u_low_max result: got %h expected 00000001", res); end
    endtask

    task automatic test_signed();
        int lat, pulses, st;
        logic [31:0] res;
        logic [4:0] ao;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd5, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'h0000_0000) begin errors++; $display("[TB] FAIL s_high_minint result: got %h expected 00000000", res); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd5, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'h8000_0000) begin errors++; $display("[TB] FAIL s_low_minint result: got %h expected 80000000", res); end
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 5'd6, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL s_high_m3x7 result: got %h expected ffffffff", res); end
        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, 5'd6, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL s_low_m3x7 result: got %h expected ffffffeb", res); end
        // Same bits read unsigned: 0xFFFFFFFD * 7 = 0x6_FFFFFFEB
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 5'd6, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'h0000_0006) begin errors++; $display("[TB] FAIL u_high_fffd_x7 result: got %h expected 00000006", res); end
    endtask

    task automatic test_back_to_back();
        int pulses, first, second;
        logic [31:0] r1, r2;
        logic [4:0] a1, a2;
        pulses = 0;
        first = -1;
        second = -1;
        r1 = 32'd0; r2 = 32'd0; a1 = 5'd0; a2 = 5'd0;
        @(negedge clk);
        mul_en_in = 1'b1;
        mul_sr0 = 32'd6;
        mul_sr1 = 32'd7;
        mul_op = 1'b0;
        mul_sign = 1'b0;
        mul_addr_in = 5'd9;
        @(posedge clk);
        #1;
        mul_en_in = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk);
            #1;
            mul_en_in = 1'b0;
            if (k == 5) begin
                mul_en_in = 1'b1;
                mul_sr0 = 32'd100;
                mul_sr1 = 32'd100;
                mul_addr_in = 5'd1;
            end
            if (mul_en_out) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    r1 = mul_result;
                    a1 = mul_addr_out;
                    mul_en_in = 1'b1;
                    mul_sr0 = 32'd11;
                    mul_sr1 = 32'd13;
                    mul_addr_in = 5'd2;
                end else if (second < 0) begin
                    second = k;
                    r2 = mul_result;
                    a2 = mul_addr_out;
                end
            end
        end
        checks++;
        if (pulses !== 2) begin errors++; $display("[TB] FAIL b2b pulses: got %0d expected 2", pulses); end
        checks++;
        if (first !== 17) begin errors++; $display("[TB] FAIL b2b first latency: got %0d expected 17", first); end
        checks++;
        if (r1 !== 32'd42) begin errors++; $display("[TB] FAIL b2b first result: got %0d expected 42", r1); end
        checks++;
        if (a1 !== 5'd9) begin errors++; $display("[TB] FAIL b2b first addr: got %0d expected 9", a1); end
        checks++;
        if (second !== 35) begin errors++; $display("[TB] FAIL b2b second latency: got %0d expected 35", second); end
        checks++;
        if (r2 !== 32'd143) begin errors++; $display("[TB] FAIL b2b second result: got %0d expected 143", r2); end
        checks++;
        if (a2 !== 5'd2) begin errors++; $display("[TB] FAIL b2b second addr: got %0d expected 2", a2); end
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        @(negedge clk);
        mul_en_in = 1'b1;
        mul_sr0 = 32'hFFFF_FFFF;
        mul_sr1 = 32'hFFFF_FFFF;
        mul_op = 1'b0;
        mul_sign = 1'b0;
        mul_addr_in = 5'd7;
        @(posedge clk);
        #1;
        mul_en_in = 1'b0;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) mul_flush = 1'b1;
            if (k == 8) begin
                mul_flush = 1'b0;
                checks++;
                if (stall_because_mul !== 1'b0) begin errors++; $display("[TB] FAIL flush stall: got %b expected 0", stall_because_mul); end
            end
            if (mul_en_out) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("[TB] FAIL flush pulses: got %0d expected 0", pulses); end
        checks++;
        if (mul_result !== 32'd143) begin errors++; $display("[TB] FAIL flush result held: got %0d expected 143", mul_result); end
        checks++;
        if (mul_addr_out !== 5'd2) begin errors++; $display("[TB] FAIL flush addr held: got %0d expected 2", mul_addr_out); end

        // A request arriving together with flush is dropped.
        @(negedge clk);
        mul_en_in = 1'b1;
        mul_flush = 1'b1;
        @(posedge clk);
        #1;
        mul_en_in = 1'b0;
        mul_flush = 1'b0;
        checks++;
        if (stall_because_mul !== 1'b0) begin errors++; $display("[TB] FAIL flush_with_en stall: got %b expected 0", stall_because_mul); end
        pulses = 0;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            if (mul_en_out) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("[TB] FAIL flush_with_en pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge clk);
        mul_en_in = 1'b1;
        mul_sr0 = 32'd5;
        mul_sr1 = 32'd5;
        mul_op = 1'b0;
        mul_sign = 1'b0;
        mul_addr_in = 5'd4;
        @(posedge clk);
        #1;
        mul_en_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (stall_because_mul !== 1'b0) begin errors++; $display("[TB] FAIL async_reset stall: got %b expected 0", stall_because_mul); end
        checks++;
        if (mul_result !== 32'd0) begin errors++; $display("[TB] FAIL async_reset result: got %h expected 00000000", mul_result); end
        checks++;
        if (mul_addr_out !== 5'd0) begin errors++; $display("[TB] FAIL async_reset addr: got %0d expected 0", mul_addr_out); end
        checks++;
        if (mul_en_out !== 1'b0) begin errors++; $display("[TB] FAIL async_reset en_out: got %b expected 0", mul_en_out); end
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (mul_en_out) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("[TB] FAIL reset_release pulses: got %0d expected 0", pulses); end
        checks++;
        if (stall_because_mul !== 1'b0) begin errors++; $display("[TB] FAIL reset_release stall: got %b expected 0", stall_because_mul); end
    endtask

    task automatic test_early_exit();
        int lat, pulses, st;
        int exp_lat_zero, exp_lat_three;
        logic [31:0] res;
        logic [4:0] ao;
`ifdef MUL_EARLY_EXIT_EN
        exp_lat_zero = 2;
        exp_lat_three = 3;
`else
        exp_lat_zero = 17;
        exp_lat_three = 17;
`endif
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 5'd12, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'd0) begin errors++; $display("[TB] FAIL zero_mplier result: got %h expected 00000000", res); end
        checks++;
        if (lat !== exp_lat_zero) begin errors++; $display("[TB] FAIL zero_mplier latency: got %0d expected %0d", lat, exp_lat_zero); end
        checks++;
        if (pulses !== 1) begin errors++; $display("[TB] FAIL zero_mplier pulses: got %0d expected 1", pulses); end
        run_op(32'd5, 32'd3, 1'b0, 1'b0, 5'd13, lat, pulses, st, res, ao);
        checks++;
        if (res !== 32'd15) begin errors++; $display("[TB] FAIL small_mplier result: got %0d expected 15", res); end
        checks++;
        if (lat !== exp_lat_three) begin errors++; $display("[TB] FAIL small_mplier latency: got %0d expected %0d", lat, exp_lat_three); end
        checks++;
        if (ao !== 5'd13) begin errors++; $display("[TB] FAIL small_mplier addr: got %0d expected 13", ao); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_early_exit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
